rsa_prime_picker: RTL and testbench

Draws two distinct 16-bit primes (p, q) for RSA key generation from the synchronous prime-table ROM (16-bit words, 13-bit address, addresses 0..6800, registered read with one-cycle latency). A free-running 13-bit LFSR supplies the random indices. The picker drives the ROM address, captures the returned words, rejects out-of-range indices and duplicate primes, and hands (p, q) to the modulus/key stage with a start/done handshake.

---
 rtl/rsa_prime_picker_if.sv | 31 +++
 rtl/rsa_prime_picker.sv | 109 ++++++++++
 tb/tb_rsa_prime_picker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_prime_picker_if.sv
// Picker <-> requester / prime ROM bundle.
// The requester side also models the registered ROM.
interface rsa_prime_picker_if;
    logic        start;
    logic [12:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] p;
    logic [15:0] q;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output rom_data,
        input  rom_addr,
        input  p,
        input  q,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rom_data,
        output rom_addr,
        output p,
        output q,
        output busy,
        output done
    );
endinterface

// File: rtl/rsa_prime_picker.sv
// Picks two distinct primes from the prime-table ROM using LFSR indices.
// Out-of-range indices and duplicate primes are redrawn.
module rsa_prime_picker #(
    parameter int unsigned MAX_ADDR = 6800,
    parameter logic [12:0] SEED     = 13'h1ACE
) (
    input logic          clk,
    input logic          rst,
    rsa_prime_picker_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRAW_P,
        WAIT_P,
        CAPT_P,
        DRAW_Q,
        WAIT_Q,
        CAPT_Q,
        DONE
    } state_t;

    // An all-zero seed would lock the LFSR up.
    localparam logic [12:0] SEED_INIT = (SEED == 13'd0) ? 13'd1 : SEED;
    localparam logic [12:0] MAX_A     = 13'(MAX_ADDR);

    state_t      state;
    state_t      state_nx;
    logic [12:0] lfsr;
    logic [12:0] addr_r;
    logic [12:0] addr_nx;
    logic [15:0] p_r;
    logic [15:0] p_nx;
    logic [15:0] q_r;
    logic [15:0] q_nx;
    logic        in_range;
    logic        fb;

    assign in_range = (lfsr <= MAX_A);
    assign fb       = lfsr[12] ^ lfsr[11] ^ lfsr[10] ^ lfsr[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= SEED_INIT;
            addr_r <= 13'd0;
            p_r    <= 16'd0;
            q_r    <= 16'd0;
        end else begin
            state  <= state_nx;
            lfsr   <= {lfsr[11:0], fb};
            addr_r <= addr_nx;
            p_r    <= p_nx;
            q_r    <= q_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_r;
        p_nx     = p_r;
        q_nx     = q_r;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = DRAW_P;
                    p_nx     = 16'd0;
                    q_nx     = 16'd0;
                end
            end
            DRAW_P: begin
                if (in_range) begin
                    addr_nx  = lfsr;
                    state_nx = WAIT_P;
                end
            end
            WAIT_P: state_nx = CAPT_P;
            CAPT_P: begin
                p_nx     = bus.rom_data;
                state_nx = DRAW_Q;
            end
            DRAW_Q: begin
                if (in_range) begin
                    addr_nx  = lfsr;
                    state_nx = WAIT_Q;
                end
            end
            WAIT_Q: state_nx = CAPT_Q;
            CAPT_Q: begin
                // q must differ from p, so a repeat costs a full redraw.
                if (bus.rom_data == p_r) begin
                    state_nx = DRAW_Q;
                end else begin
                    q_nx     = bus.rom_data;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rom_addr = addr_r;
    assign bus.p        = p_r;
    assign bus.q        = q_r;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_rsa_prime_picker.sv
// Randomized-timing bench for rsa_prime_picker against a sequence-level model.
// Two instances: seed 1 (main scenarios) and seed 1FFF (rejection path).
module tb_rsa_prime_picker;

    localparam logic [12:0] MAXA = 13'd6800;

    logic clk;
    logic rst;
    logic st [2];
    logic dup_mode;
    logic [15:0] dup_val;
    logic [12:0] mlf [2];

    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] p_w [2];
    logic [15:0] q_w [2];
    logic [12:0] addr_w [2];

    int n_chk;
    int n_fail;

    int          e_pk;
    int          e_cp;
    int          e_cq;
    int          e_de;
    logic [12:0] e_pa;
    logic [12:0] e_qa;
    logic [15:0] e_p;
    logic [15:0] e_q;

    rsa_prime_picker_if ifa ();
    rsa_prime_picker_if ifb ();

    rsa_prime_picker #(.MAX_ADDR(6800), .SEED(13'h0001)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    rsa_prime_picker #(.MAX_ADDR(6800), .SEED(13'h1FFF)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    assign ifa.start = st[0];
    assign ifb.start = st[1];
    assign busy_w[0] = ifa.busy;
    assign busy_w[1] = ifb.busy;
    assign done_w[0] = ifa.done;
    assign done_w[1] = ifb.done;
    assign p_w[0]    = ifa.p;
    assign p_w[1]    = ifb.p;
    assign q_w[0]    = ifa.q;
    assign q_w[1]    = ifb.q;
    assign addr_w[0] = ifa.rom_addr;
    assign addr_w[1] = ifb.rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] step(input logic [12:0] s);
        logic fb;
        fb = ^(s & 13'h1C80);
        return 13'((s << 1) | {12'd0, fb});
    endfunction

    function automatic logic [15:0] romv(input logic [12:0] a,
                                         input bit dupm, input int n);
        if (dupm) return (n < 2) ? 16'd65521 : 16'd65519;
        return {3'd0, a} + 16'd2;
    endfunction

    // Bench-side ROMs with one-cycle registered read.
    always @(posedge clk) begin
        ifa.rom_data <= dup_mode ? dup_val : ({3'd0, ifa.rom_addr} + 16'd2);
        ifb.rom_data <= {3'd0, ifb.rom_addr} + 16'd2;
    end

    // Reference LFSR per instance: value held between edges.
    always @(posedge clk) begin
        if (rst) begin
            mlf[0] <= 13'h0001;
            mlf[1] <= 13'h1FFF;
        end else begin
            mlf[0] <= step(mlf[0]);
            mlf[1] <= step(mlf[1]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // v1 is the LFSR value presented at edge E1; k counts edges from E0.
    task automatic predict(input logic [12:0] v1, input bit dupm);
        logic [12:0] v;
        logic [15:0] d;
        int k;
        int n;
        bit fin;
        v = v1; k = 1; n = 0; fin = 0;
        while (v > MAXA && k < 9000) begin v = step(v); k++; end
        e_pk = k; e_pa = v; e_p = romv(v, dupm, n); n++;
        e_cp = k + 2; e_cq = 0; e_de = 9000;
        repeat (3) v = step(v);
        k += 3;
        while (!fin && k < 9000) begin
            while (v > MAXA && k < 9000) begin v = step(v); k++; end
            d = romv(v, dupm, n); n++;
            if (e_cq == 0) e_cq = k + 2;
            if (d != e_p) begin
                e_qa = v; e_q = d; e_de = k + 2; fin = 1;
            end else begin
                repeat (3) v = step(v);
                k += 3;
            end
        end
    endtask

    task automatic run(input int i, input bit keep);
        st[i] = 1'b1;
        @(posedge clk); #1;
        if (!keep) st[i] = 1'b0;
        chk("busy_e0", busy_w[i], 1);
        chk("done_e0", done_w[i], 0);
        chk("p_clr", p_w[i], 0);
        chk("q_clr", q_w[i], 0);
        predict(mlf[i], (i == 0) && dup_mode);
        for (int k = 1; k <= e_de + 1; k++) begin
            @(posedge clk); #1;
            if (i == 0 && dup_mode && k == e_cq) dup_val = 16'd65519;
            chk("done", done_w[i], (k == e_de));
            chk("busy", busy_w[i], (k <= e_de));
            chk("addr_rng", (addr_w[i] <= MAXA), 1);
            if (k == e_pk) chk("addr_p", addr_w[i], e_pa);
            if (k == e_cp) chk("p_cap", p_w[i], e_p);
            if (k == e_de) begin
                chk("q_cap", q_w[i], e_q);
                chk("p_fin", p_w[i], e_p);
                chk("addr_q", addr_w[i], e_qa);
                chk("p_ne_q", (p_w[i] != q_w[i]), 1);
            end
        end
    endtask

    task automatic idle_hold(input int i, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            chk("idle_busy", busy_w[i], 0);
            chk("idle_done", done_w[i], 0);
            chk("hold_p", p_w[i], e_p);
            chk("hold_q", q_w[i], e_q);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
            chk("rst_addr", addr_w[i], 0);
            chk("rst_p", p_w[i], 0);
            chk("rst_q", q_w[i], 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        st[0] = 1'b0;
        st[1] = 1'b0;
        dup_mode = 1'b0;
        dup_val = 16'd65521;
        rst = 1'b1;

        // Seed 1FFF: first indices out of range.
        do_reset(3);
        run(1, 0);
        idle_hold(1, 2);

        // Reset then start one cycle later.
        do_reset(3);
        run(0, 0);
        idle_hold(0, 3);

        // Duplicate prime forces a q redraw.
        dup_mode = 1'b1;
        dup_val = 16'd65521;
        idle_hold(0, $urandom_range(0, 5));
        run(0, 0);
        chk("dup_p", e_p, 16'd65521);
        chk("dup_q_dut", q_w[0], 16'd65519);
        dup_mode = 1'b0;
        idle_hold(0, 2);

        // start held through DONE; next run only after DONE.
        run(0, 1);
        run(0, 0);
        idle_hold(0, 2);

        // Reset two edges into a run.
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", busy_w[0], 1);
        do_reset(1);
        run(0, 0);
        idle_hold(0, 1);

        for (int r = 0; r < 10; r++) begin
            idle_hold(0, $urandom_range(0, 20));
            run(0, 0);
        end
        idle_hold(0, 2);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 30)) @(posedge clk);
            #1;
            run(1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
